// File: rtl/misc_clint_multi_pkg.sv
// Shared definitions for the misc/CLINT MMIO device: bus widths, register
// offsets, a snapshot struct of the architectural state and the byte-merge
// helper used by every writable register.
package misc_clint_multi_pkg;

  localparam int MISC_ADDR_WIDTH = 12;
  localparam int MISC_DATA_WIDTH = 64;
  localparam int MAX_HARTS       = 8;

  localparam int MTIME_REG_OFFSET   = 'h000;
  localparam int DISPLAY_REG_OFFSET = 'h008;
  localparam int TICKDIV_REG_OFFSET = 'h010;
  localparam int MTIMECMP_BASE      = 'h100;
  localparam int MSIP_BASE          = 'h200;
  localparam int HART_STRIDE        = 8;

  // Snapshot of the device's architectural state, sized for the largest build.
  typedef struct packed {
    logic [MISC_DATA_WIDTH-1:0]                mtime;
    logic [MISC_DATA_WIDTH-1:0]                display;
    logic [MISC_DATA_WIDTH-1:0]                tick_div;
    logic [MAX_HARTS-1:0][MISC_DATA_WIDTH-1:0] mtimecmp;
    logic [MAX_HARTS-1:0]                      msip;
  } misc_info_t;

  // Replace each byte of old_val whose mask bit is set with the byte of new_val.
  function automatic logic [MISC_DATA_WIDTH-1:0] merge_bytes(
    input logic [MISC_DATA_WIDTH-1:0] old_val,
    input logic [MISC_DATA_WIDTH-1:0] new_val,
    input logic [7:0]                 mask
  );
    logic [MISC_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/misc_clint_multi_prescaler.sv
// mtime prescaler: counts 0..tick_div and emits a one-cycle tick on the
// wrap. clear restarts the count (divisor rewrite); halt freezes it.
module misc_prescaler
  import misc_clint_multi_pkg::*;
#(
  parameter int TICK_DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [TICK_DIV_WIDTH-1:0] tick_div,
  input  logic                      clear,
  input  logic                      halt,
  output logic                      tick
);

  localparam logic [TICK_DIV_WIDTH-1:0] ONE = 1;

  logic [TICK_DIV_WIDTH-1:0] count;

  assign tick = !halt && (count == tick_div);

  // Divisor counter; a clear wins over counting, halt holds the phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!halt) begin
      count <= tick ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/misc_clint_multi.sv
// Machine-timer / misc MMIO device for NUM_HARTS harts: free-running 64-bit
// mtime behind a prescaler, per-hart mtimecmp/msip with registered mtip/msip
// lines, and a display register. Always ready, fixed one-cycle response.
// Optional build macro MISC_CLINT_HALT_EN adds the halt_mtime input that
// freezes mtime and the prescaler.
module misc_clint_multi
  import misc_clint_multi_pkg::*;
#(
  parameter int NUM_HARTS      = 2,
  parameter int ADDR_WIDTH     = MISC_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MISC_DATA_WIDTH,
  parameter int TICK_DIV_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [7:0]            req_wmask,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [NUM_HARTS-1:0]  mtip,
  output logic [NUM_HARTS-1:0]  msip,
  output logic [DATA_WIDTH-1:0] display
`ifdef MISC_CLINT_HALT_EN
  ,
  input  logic                  halt_mtime
`endif
);

  localparam logic [DATA_WIDTH-1:0] ONE = 1;

  logic [DATA_WIDTH-1:0]     mtime;
  logic [DATA_WIDTH-1:0]     mtime_next;
  logic [TICK_DIV_WIDTH-1:0] tick_div;
  logic [DATA_WIDTH-1:0]     mtimecmp [NUM_HARTS];
  logic [DATA_WIDTH-1:0]     cmp_next [NUM_HARTS];
  logic                      sel_mtime, sel_display, sel_div;
  logic [NUM_HARTS-1:0]      sel_cmp, sel_msip;
  logic                      hit, wr, tick, halt;
  logic [DATA_WIDTH-1:0]     rdata;

`ifdef MISC_CLINT_HALT_EN
  assign halt = halt_mtime;
`else
  assign halt = 1'b0;
`endif

  // Address decode: exact-match selects, so misaligned offsets never hit.
  always_comb begin
    sel_mtime   = (req_addr == ADDR_WIDTH'(MTIME_REG_OFFSET));
    sel_display = (req_addr == ADDR_WIDTH'(DISPLAY_REG_OFFSET));
    sel_div     = (req_addr == ADDR_WIDTH'(TICKDIV_REG_OFFSET));
    sel_cmp     = '0;
    sel_msip    = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      sel_cmp[h]  = (req_addr == ADDR_WIDTH'(MTIMECMP_BASE + HART_STRIDE * h));
      sel_msip[h] = (req_addr == ADDR_WIDTH'(MSIP_BASE + HART_STRIDE * h));
    end
    hit = sel_mtime | sel_display | sel_div | (|sel_cmp) | (|sel_msip);
    // An all-zero byte mask is a legal no-op and must not steal a tick.
    wr  = req_valid & req_we & hit & (|req_wmask);
  end

  // Read mux over the pre-write register values.
  always_comb begin
    rdata = '0;
    if (sel_mtime)   rdata = mtime;
    if (sel_display) rdata = display;
    if (sel_div)     rdata = DATA_WIDTH'(tick_div);
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (sel_cmp[h])  rdata = mtimecmp[h];
      if (sel_msip[h]) rdata = DATA_WIDTH'(msip[h]);
    end
  end

  misc_prescaler #(
    .TICK_DIV_WIDTH(TICK_DIV_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rstn     (rstn),
    .tick_div (tick_div),
    .clear    (wr & sel_div),
    .halt     (halt),
    .tick     (tick)
  );

  // Next mtime / mtimecmp values; a software mtime write overrides the tick.
  always_comb begin
    mtime_next = mtime;
    if (wr && sel_mtime) mtime_next = merge_bytes(mtime, req_wdata, req_wmask);
    else if (tick)       mtime_next = mtime + ONE;
    for (int h = 0; h < NUM_HARTS; h++) begin
      cmp_next[h] = (wr && sel_cmp[h]) ? merge_bytes(mtimecmp[h], req_wdata, req_wmask)
                                       : mtimecmp[h];
    end
  end

  // Architectural registers and the registered interrupt lines.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime    <= '0;
      display  <= '0;
      tick_div <= '0;
      msip     <= '0;
      mtip     <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      mtime <= mtime_next;
      if (wr && sel_display) display  <= merge_bytes(display, req_wdata, req_wmask);
      if (wr && sel_div)
        tick_div <= TICK_DIV_WIDTH'(merge_bytes(DATA_WIDTH'(tick_div), req_wdata, req_wmask));
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp[h] <= cmp_next[h];
        if (wr && sel_msip[h] && req_wmask[0]) msip[h] <= req_wdata[0];
        mtip[h] <= (mtime_next >= cmp_next[h]);
      end
    end
  end

  // One-cycle response; writes and errors return zero data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= req_valid;
      resp_err   <= req_valid & ~hit;
      resp_rdata <= (req_valid && !req_we) ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_misc_clint_multi.sv
// Self-checking bench for misc_clint_multi with a cycle-level reference
// model built from the register-map rules (prescaler as a phase counter
// modulo tick_div+1). Directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_misc_clint_multi;

  localparam int NH = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_we;
  logic [11:0]   req_addr;
  logic [63:0]   req_wdata;
  logic [7:0]    req_wmask;
  logic          resp_valid, resp_err;
  logic [63:0]   resp_rdata, display;
  logic [NH-1:0] mtip, msip;
  logic          halt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0]   m_mtime, m_disp;
  logic [15:0]   m_div;
  int            m_phase;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip;
  logic          exp_valid, exp_err;
  logic [63:0]   exp_rdata;
  logic [NH-1:0] exp_mtip;

  always #5 clk = ~clk;

  misc_clint_multi #(.NUM_HARTS(NH)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mtip(mtip), .msip(msip), .display(display)
`ifdef MISC_CLINT_HALT_EN
    , .halt_mtime(halt)
`endif
  );

  function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] n,
                                         input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_mtime = '0; m_disp = '0; m_div = '0; m_phase = 0; m_msip = '0;
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
    exp_valid = 0; exp_err = 0; exp_rdata = '0; exp_mtip = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int a, kind, idx, period;
    logic [63:0] rd;
    logic wr, tick;
    a = int'(req_addr); kind = -1; idx = 0; rd = '0;
    if (a == 0)       begin kind = 0; rd = m_mtime; end
    else if (a == 8)  begin kind = 1; rd = m_disp; end
    else if (a == 16) begin kind = 2; rd = {48'd0, m_div}; end
    else if (a >= 'h100 && a < 'h100 + 8*NH && a % 8 == 0) begin
      kind = 3; idx = (a - 'h100) / 8; rd = m_cmp[idx];
    end else if (a >= 'h200 && a < 'h200 + 8*NH && a % 8 == 0) begin
      kind = 4; idx = (a - 'h200) / 8; rd = {63'd0, m_msip[idx]};
    end
    exp_valid = req_valid;
    exp_err   = req_valid && kind < 0;
    exp_rdata = (req_valid && !req_we && kind >= 0) ? rd : 64'd0;
    wr = req_valid && req_we && kind >= 0 && req_wmask != 0;
    period = int'(m_div) + 1;
    tick = !halt && (m_phase + 1 == period);
    if (!halt) m_phase = (m_phase + 1) % period;
    if (wr && kind == 0) m_mtime = bmerge(m_mtime, req_wdata, req_wmask);
    else if (tick)       m_mtime = m_mtime + 64'd1;
    if (wr && kind == 1) m_disp = bmerge(m_disp, req_wdata, req_wmask);
    if (wr && kind == 2) begin
      m_div = bmerge({48'd0, m_div}, req_wdata, req_wmask) & 64'hFFFF;
      m_phase = 0;
    end
    if (wr && kind == 3) m_cmp[idx] = bmerge(m_cmp[idx], req_wdata, req_wmask);
    if (wr && kind == 4 && req_wmask[0]) m_msip[idx] = req_wdata[0];
    for (int h = 0; h < NH; h++) exp_mtip[h] = (m_mtime >= m_cmp[h]);
  endtask

  task automatic clk_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [11:0] addr, input logic [63:0] wd,
                     input logic [7:0] wm);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wmask = wm;
    clk_step();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
  endtask

  task automatic test_reset();
    rstn = 0; halt = 0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    model_reset();
    #12;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, mtip, msip, display} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b e=%b rd=%h mtip=%b msip=%b disp=%h want all 0",
               resp_valid, resp_err, resp_rdata, mtip, msip, display);
    end
    @(posedge clk); #1;
    rstn = 1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) clk_step();
    req(0, 12'h000, 0, 0);
    checks++;
    if (resp_rdata !== 64'd10 || resp_rdata !== exp_rdata) begin
      errors++; $display("FAIL idle_mtime got %0d want 10 (model %0d)", resp_rdata, exp_rdata);
    end
    for (int h = 0; h < NH; h++) begin
      req(0, 12'(12'h100 + 8*h), 0, 0);
      checks++;
      if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FFFF || resp_err !== 1'b0) begin
        errors++; $display("FAIL reset_mtimecmp%0d got %h err=%b want all-ones", h, resp_rdata, resp_err);
      end
    end
    checks++;
    if (mtip !== '0 || msip !== '0) begin
      errors++; $display("FAIL idle_irq got mtip=%b msip=%b want 0", mtip, msip);
    end
  endtask

  task automatic test_prescaler();
    req(1, 12'h010, 64'd3, 8'hFF);
    req(1, 12'h000, 64'd0, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      req(0, 12'h000, 0, 0);
      checks++;
      if (resp_rdata !== exp_rdata) begin
        errors++; $display("FAIL presc_mtime[%0d] got %0d want %0d", i, resp_rdata, exp_rdata);
      end
    end
    checks++;
    if (resp_rdata !== 64'd10) begin
      errors++; $display("FAIL presc_final got %0d want 10", resp_rdata);
    end
    req(0, 12'h010, 0, 0);
    checks++;
    if (resp_rdata !== 64'd3) begin
      errors++; $display("FAIL tickdiv_read got %h want 3", resp_rdata);
    end
  endtask

  task automatic test_mtip();
    req(1, 12'h010, 64'd0, 8'hFF);
    req(1, 12'h000, 64'd0, 8'hFF);
    req(1, 12'h108, 64'd20, 8'hFF);
    for (int i = 0; i < 30; i++) begin
      clk_step();
      checks++;
      if (mtip !== exp_mtip || mtip[0] !== 1'b0) begin
        errors++; $display("FAIL mtip_cycle%0d got %b want %b", i, mtip, exp_mtip);
      end
    end
    checks++;
    if (mtip[1] !== 1'b1) begin
      errors++; $display("FAIL mtip1_raised got %b want 1", mtip[1]);
    end
    req(1, 12'h108, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    checks++;
    if (mtip[1] !== 1'b0 || mtip !== exp_mtip) begin
      errors++; $display("FAIL mtip1_cleared got %b want 0", mtip[1]);
    end
  endtask

  task automatic test_msip();
    req(1, 12'h200, 64'hFF, 8'h01);
    checks++;
    if (msip !== 2'b01) begin
      errors++; $display("FAIL msip_set got %b want 01", msip);
    end
    req(0, 12'h200, 0, 0);
    checks++;
    if (resp_rdata !== 64'h1) begin
      errors++; $display("FAIL msip_read1 got %h want 1", resp_rdata);
    end
    req(1, 12'h200, 64'h0, 8'hFF);
    checks++;
    if (msip !== 2'b00) begin
      errors++; $display("FAIL msip_clear got %b want 00", msip);
    end
    req(0, 12'h200, 0, 0);
    checks++;
    if (resp_rdata !== 64'h0) begin
      errors++; $display("FAIL msip_read0 got %h want 0", resp_rdata);
    end
  endtask

  task automatic test_errors();
    req(0, 12'(12'h100 + 8*NH), 0, 0);
    checks++;
    if (resp_err !== 1'b1 || resp_rdata !== 64'd0 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL err_cmp_oob got err=%b rd=%h want err=1 rd=0", resp_err, resp_rdata);
    end
    req(0, 12'h004, 0, 0);
    checks++;
    if (resp_err !== 1'b1 || resp_rdata !== 64'd0) begin
      errors++; $display("FAIL err_misaligned got err=%b rd=%h want err=1 rd=0", resp_err, resp_rdata);
    end
    req(1, 12'h00C, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    checks++;
    if (resp_err !== 1'b1 || display !== 64'd0) begin
      errors++; $display("FAIL err_write got err=%b disp=%h want err=1 disp=0", resp_err, display);
    end
    req(1, 12'h008, 64'hDEAD_BEEF_0123_4567, 8'h0F);
    checks++;
    if (display !== 64'h0000_0000_0123_4567 || resp_err !== 1'b0) begin
      errors++; $display("FAIL display_mask got %h want 0000000001234567", display);
    end
    req(1, 12'h008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    checks++;
    if (display !== 64'h0000_0000_0123_4567 || resp_err !== 1'b0) begin
      errors++; $display("FAIL wmask_zero got disp=%h err=%b want unchanged err=0", display, resp_err);
    end
  endtask

  task automatic test_write_tick();
    req(1, 12'h010, 64'd0, 8'hFF);
    req(1, 12'h000, 64'h1234, 8'hFF);
    req(0, 12'h000, 0, 0);
    checks++;
    if (resp_rdata !== 64'h1234) begin
      errors++; $display("FAIL write_beats_tick got %h want 1234", resp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [3];
    addrs[0] = 12'h008; addrs[1] = 12'h000; addrs[2] = 12'h108;
    for (int i = 0; i < 3; i++) begin
      req(0, addrs[i], 0, 0);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d got v=%b rd=%h want v=1 rd=%h", i, resp_valid, resp_rdata, exp_rdata);
      end
    end
    clk_step();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got v=%b want 0", resp_valid);
    end
  endtask

  task automatic test_random();
    logic [11:0] pool [13];
    pool = '{12'h000, 12'h008, 12'h010, 12'h100, 12'h108, 12'h110, 12'h200,
             12'h208, 12'h210, 12'h004, 12'h0FF, 12'h300, 12'h018};
    for (int i = 0; i < 400; i++) begin
`ifdef MISC_CLINT_HALT_EN
      halt = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 0;
      end else begin
        req_valid = 1;
        req_we    = $urandom_range(0, 1) == 1;
        req_addr  = pool[$urandom_range(0, 12)];
        req_wdata = {$urandom, $urandom};
        req_wmask = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        if (req_addr == 12'h010) req_wdata = 64'($urandom_range(0, 4));
        if (req_addr == 12'h100 || req_addr == 12'h108)
          req_wdata = m_mtime + 64'($urandom_range(0, 8));
      end
      clk_step();
      checks++;
      if ({resp_valid, resp_err, resp_rdata, mtip, msip, display} !==
          {exp_valid, exp_err, exp_rdata, exp_mtip, m_msip, m_disp}) begin
        errors++;
        $display("FAIL random_%0d got v=%b e=%b rd=%h mtip=%b msip=%b disp=%h want v=%b e=%b rd=%h mtip=%b msip=%b disp=%h",
                 i, resp_valid, resp_err, resp_rdata, mtip, msip, display,
                 exp_valid, exp_err, exp_rdata, exp_mtip, m_msip, m_disp);
      end
    end
    req_valid = 0; halt = 0;
  endtask

  task automatic test_reset_mid();
    req(1, 12'h008, 64'h55, 8'hFF);
    req_valid = 1; req_we = 0; req_addr = 12'h000;
    clk_step();
    req_valid = 0;
    #2 rstn = 0;
    #1;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, mtip, msip, display} !== '0) begin
      errors++; $display("FAIL reset_mid got v=%b rd=%h disp=%h want all 0", resp_valid, resp_rdata, display);
    end
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
    req(0, 12'h100, 0, 0);
    checks++;
    if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL reset_mid_cmp got %h want all-ones", resp_rdata);
    end
  endtask

`ifdef MISC_CLINT_HALT_EN
  task automatic test_halt();
    req(1, 12'h010, 64'd0, 8'hFF);
    halt = 1;
    req(1, 12'h000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      req(0, 12'h000, 0, 0);
      checks++;
      if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FFFE) begin
        errors++; $display("FAIL halt_hold%0d got %h want fffffffffffffffe", i, resp_rdata);
      end
    end
    halt = 0;
    clk_step();
    clk_step();
    req(0, 12'h000, 0, 0);
    checks++;
    if (resp_rdata !== 64'd0 || resp_rdata !== exp_rdata) begin
      errors++; $display("FAIL halt_wrap got %h want 0", resp_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_prescaler();
    test_mtip();
    test_msip();
    test_errors();
    test_write_tick();
    test_back_to_back();
`ifdef MISC_CLINT_HALT_EN
    test_halt();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/misc_clint_multi.md
Name: misc_clint_multi

Overview:
Parametrised machine-timer/misc MMIO device for N harts.
- Free-running 64-bit mtime with programmable prescaler.
- Per-hart mtimecmp and msip registers driving registered timer/software interrupt lines.
- One display register for the debug/console path.
- Sits on the core's MMIO port behind the memory-map decoder, one request per cycle, fixed one-cycle response.

Parameters:
NUM_HARTS, 2, number of harts; 1..8 legal
ADDR_WIDTH, 12, MMIO offset width
DATA_WIDTH, 64, bus data width; only 64 supported
TICK_DIV_WIDTH, 16, width of prescaler divisor register

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
req_valid  in  1  MMIO request
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte offset, 8-byte aligned
req_wdata  in  64  write data
req_wmask  in  8  byte enables for writes
resp_valid  out  1  response strobe, exactly one cycle after accepted request
resp_rdata  out  64  read data (0 for writes)
resp_err  out  1  unmapped or misaligned access
mtip  out  NUM_HARTS  per-hart timer interrupt pending
msip  out  NUM_HARTS  per-hart software interrupt pending
display  out  64  display register value
halt_mtime  in  1  present only with MISC_CLINT_HALT_EN

Behaviour:
Reset: all outputs 0; mtime=0; mtimecmp[h]=all-ones; msip=0; display=0; tick_div=0; prescaler count=0.

Address map:
- 0x000 mtime
- 0x008 display
- 0x010 tick_div (low TICK_DIV_WIDTH bits; rest read 0)
- 0x100+8h mtimecmp[h]
- 0x200+8h msip[h] (bit 0 only)
- h >= NUM_HARTS, other offsets, or addr[2:0]!=0: resp_err=1, read data 0, no state change.

Handshake:
- Always ready; every req_valid cycle is accepted.
- resp_valid, resp_rdata and resp_err are registered and valid the next cycle.
- Back-to-back requests give back-to-back responses.

Writes:
- Byte-merge under req_wmask.
- wmask=0 is a legal no-op with resp_err=0.

Prescaler:
- Counter runs 0..tick_div and increments mtime by 1 on wrap.
- tick_div=0 means mtime increments every cycle; tick_div=N means every N+1 cycles.
- Writing tick_div resets the prescaler count to 0.

mtime:
- Wraps 2^64-1 -> 0.
- A software write in the same cycle as a tick wins; the tick is lost and the prescaler count is not reset.

Interrupts:
- mtip[h] is registered: next cycle = (mtime_next >= mtimecmp_next[h]), unsigned.
- Consequently mtip deasserts the cycle after a mtimecmp write that raises it.
- msip[h] = msip register bit 0.

Reads:
- Return the pre-write register value (read-before-write).
- A read of mtime returns the value sampled in the request cycle.

Reset mid-operation: asynchronous clear of all state; a pending response is dropped (resp_valid=0).

Optional Feature:
MISC_CLINT_HALT_EN:
- Defined: halt_mtime port exists. While it is 1, the prescaler and mtime freeze. Software writes still take effect. mtip is still evaluated.
- Undefined: the port is absent and mtime always runs.

Decomposition:
Shared package:
- MISC_ADDR_WIDTH and MISC_DATA_WIDTH.
- Offsets MTIME_REG_OFFSET=0x000, DISPLAY_REG_OFFSET=0x008, TICKDIV_REG_OFFSET=0x010, MTIMECMP_BASE=0x100, MSIP_BASE=0x200, HART_STRIDE=8.
- MiscInfo struct extended with mtimecmp and msip arrays sized by a MAX_HARTS constant.
- Byte-mask merge function.

Sub-module misc_prescaler holds the divisor counter and tick/clear/halt inputs and emits a 1-cycle tick.

Test Plan:
- Reset, then idle 10 cycles with tick_div=0 -> mtime reads 10 (±request-cycle offset); mtip=0, msip=0, all mtimecmp read 0xFFFF_FFFF_FFFF_FFFF.
- Write tick_div=3, then write mtime=0 and run 40 cycles -> mtime=10; mtime stays stable across each 4-cycle window.
- Write mtimecmp[1]=20 with mtime=0, tick_div=0 -> mtip[1] rises in the cycle mtime reaches 20, mtip[0] stays 0. Write mtimecmp[1]=all-ones -> mtip[1]=0 next cycle.
- Write msip[0]=0xFF with wmask=0x01 -> msip[0]=1. Write 0 -> msip[0]=0. Read back returns 0x1 and 0x0.
- Read 0x100+8*NUM_HARTS and read 0x004 -> resp_err=1, rdata=0, no state change. Write display=0xDEAD_BEEF_0123_4567 with wmask=0x0F -> display=0x0000_0000_0123_4567.
- With MISC_CLINT_HALT_EN: mtime=0xFFFF_FFFF_FFFF_FFFE, halt=1 for 5 cycles -> unchanged. Release -> wraps to 0 after 2 cycles. Write mtime on a tick cycle -> written value holds.
